ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as reset (0xFF) and set-LEDs (0xED) plus argument. It is the transmit counterpart of the existing `ps2` receiver and shares the same `ps2Clk`/`ps2Data` open-drain lines. The block sits in the `cpuClock` (25 MHz) domain next to `ps2_kbd`. Top level drives each line low when the matching `*_oe` is 1 and releases it (`1'bz`) otherwise. The receiver must ignore frames while `busy` is 1.

---
 rtl/ps2_host_tx.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter (inhibit, start, d0..d7, odd parity, stop, ACK).
// The optional watchdog is compiled in when PS2_HOST_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic [2:0] state_dbg
);

  // Handshake: a request transfers on a rising clk edge where tx_valid and tx_ready are
  // both 1; tx_data is sampled only then, and tx_valid while not ready is dropped.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_START     = 3'd2,
    S_BITS      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES);

  state_t state_q, state_d;

  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [3:0]       n_q, n_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic             err_q, err_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic clk_fall;
  logic timeout;

  // Lines idle high, so the synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign clk_fall = clk_prev & ~clk_s2;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q;
  logic            watch;

  assign watch   = (state_q == S_BITS) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  // Fires in the cycle the count reaches the limit, so tx_done lands exactly
  // TIMEOUT_CYCLES cycles after the clock line is released.
  assign timeout = watch && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && tx_valid) begin
      wd_cnt_q <= '0;
    end else if (watch && (wd_cnt_q != WD_MAX)) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    n_d       = n_q;
    inh_cnt_d = inh_cnt_q;
    err_d     = err_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    if (timeout) begin
      data_oe_d = 1'b0;
      done_d    = 1'b1;
      error_d   = 1'b1;
      state_d   = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          data_oe_d = 1'b0;
          if (tx_valid) begin
            shift_d   = tx_data;
            parity_d  = ~^tx_data;
            n_d       = 4'd0;
            inh_cnt_d = '0;
            err_d     = 1'b0;
            state_d   = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt_q != INH_MAX) inh_cnt_d = inh_cnt_q + INH_W'(1);
          if (inh_cnt_q >= INH_LAST) begin
            data_oe_d = 1'b1;
            state_d   = S_START;
          end
        end
        S_START: begin
          state_d = S_BITS;
        end
        S_BITS: begin
          // n_q is the number of falls seen so far: 0..7 data, 8 parity, 9 stop.
          if (clk_fall) begin
            n_d = n_q + 4'd1;
            if (n_q < 4'd8) begin
              data_oe_d = ~shift_q[0];
              shift_d   = {1'b0, shift_q[7:1]};
            end else if (n_q == 4'd8) begin
              data_oe_d = ~parity_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = S_ACK;
            end
          end
        end
        S_ACK: begin
          if (clk_fall) begin
            err_d   = data_s2;
            state_d = S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (clk_s2 && data_s2) begin
            done_d  = 1'b1;
            error_d = err_q;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end
      endcase
    end

    clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_START);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      n_q       <= 4'd0;
      inh_cnt_q <= '0;
      err_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      n_q       <= n_d;
      inh_cnt_q <= inh_cnt_d;
      err_q     <= err_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign state_dbg   = state_q;

endmodule
